// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit
// timing. Used by uart_rx now and intended for the transmitter as well.
package uart_pkg;

  // Receiver FSM states; PARITY is only reachable with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // 24 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 208;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge
// detect. All flops reset to 1 (line idle) so reset never fakes an edge
// out of stale state.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Synchronizer chain and one-cycle history of the synchronized line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_s = rx_sync;
  assign fall = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1/8O1 when UART_RX_PARITY_EN is defined).
// Bit timing comes from CLKS_PER_BIT; the line is sampled mid-bit after a
// mid-start-bit false-start check.
//
// Output strobes: valid_o, frame_err_o and parity_err_o are mutually
// exclusive one-cycle pulses with no back-pressure. data_o only changes in
// the cycle valid_o is high and holds that byte afterwards; error strobes
// leave data_o untouched.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           data_n;
  logic                 valid_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 perr_n;
  logic                 par_ok, par_ok_n;
`endif

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
      par_ok       <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= perr_n;
      par_ok       <= par_ok_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  // Without parity the sense parameter has no effect and the strobe is dead.
  assign parity_err_o = 1'b0 & PARITY_ODD;
`endif

  // Next-state logic: bit timing, sampling and strobe generation.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_o;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n    = 1'b0;
    par_ok_n  = par_ok;
`endif
    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
        par_ok_n  = 1'b1;
`endif
        if (fall) state_n = ST_START;
      end
      ST_START: begin
        // Mid start bit: a line back high means a glitch, not a frame.
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          par_ok_n = (rx_s == ((^shift) ^ PARITY_ODD));
          state_n  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (!par_ok) begin
            perr_n  = 1'b1;
            state_n = ST_IDLE;
`endif
          end else begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line has recovered so a break is one error.
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with CLKS_PER_BIT = 16. Frames are driven on the falling
// clock edge; expected strobes are queued by the driver and retired by a
// monitor whenever the DUT raises a strobe. Parity frames are exercised
// when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  // Clock and cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: {parity_err, frame_err, valid, data}
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;
  logic [7:0]  last_good = 8'h00;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          valid_cyc_prev = 0;
  int          valid_cyc_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ok(input logic [7:0] d);
    exp_q.push_back({3'b001, d});
    last_good = d;
  endtask

  task automatic expect_ferr();
    exp_q.push_back({3'b010, last_good});
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic expect_perr();
    exp_q.push_back({3'b100, last_good});
  endtask
`endif

  // Driver tasks
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_head(d);
`ifdef UART_RX_PARITY_EN
    hold(^d, CPB);
`endif
    hold(stop, CPB);
    if (stop) rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_head(d);
    hold(par, CPB);
    hold(1'b1, CPB);
  endtask
`endif

  // Monitor: retire one expected entry per strobe cycle
  always @(negedge clk) begin
    if (valid_o || frame_err_o || parity_err_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobes=%b data=0x%0h expected no strobe (cycle %0d)",
                 {parity_err_o, frame_err_o, valid_o}, data_o, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        check("strobe_kind", {29'd0, parity_err_o, frame_err_o, valid_o}, {29'd0, exp_e[10:8]});
        check("strobe_data", {24'd0, data_o}, {24'd0, exp_e[7:0]});
      end
      if (valid_o) begin
        valid_cyc_prev = valid_cyc_last;
        valid_cyc_last = cyc;
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data", {24'd0, data_o}, 32'h00);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err_o}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55, busy sampled mid-frame
    expect_ok(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (100) @(negedge clk);
        check("busy_mid_frame", {31'd0, busy_o}, 32'd1);
      end
    join
    hold(1'b1, 20);
    check("busy_after_frame", {31'd0, busy_o}, 32'd0);
    check("data_after_55", {24'd0, data_o}, 32'h55);

    // 5-cycle glitch is a false start
    hold(1'b0, 5);
    check("busy_glitch_start", {31'd0, busy_o}, 32'd1);
    hold(1'b1, 11);
    check("busy_glitch_reject", {31'd0, busy_o}, 32'd0);
    hold(1'b1, 10);
    expect_ok(8'hA3);
    send_frame(8'hA3, 1'b1);
    hold(1'b1, 20);

    // Low stop bit then a held-low line
    expect_ferr();
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40);
    check("busy_in_break", {31'd0, busy_o}, 32'd1);
    check("data_hold_after_ferr", {24'd0, data_o}, 32'hA3);
    hold(1'b1, 5);
    check("busy_break_released", {31'd0, busy_o}, 32'd0);
    hold(1'b1, 10);
    expect_ok(8'h81);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 20);
    check("data_after_81", {24'd0, data_o}, 32'h81);

    // Back-to-back frames, stop bit exactly one bit long
    expect_ok(8'h00);
    expect_ok(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 20);
`ifdef UART_RX_PARITY_EN
    check("b2b_spacing", valid_cyc_last - valid_cyc_prev, 32'd176);
`else
    check("b2b_spacing", valid_cyc_last - valid_cyc_prev, 32'd160);
`endif

    // Reset during data bit 3 of 0x7E
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_busy", {31'd0, busy_o}, 32'd0);
    check("midreset_data", {24'd0, data_o}, 32'h00);
    rst = 1'b0;
    last_good = 8'h00;
    hold(1'b1, 20);
    check("postreset_busy", {31'd0, busy_o}, 32'd0);
    expect_ok(8'hC5);
    send_frame(8'hC5, 1'b1);
    hold(1'b1, 20);
    check("data_after_c5", {24'd0, data_o}, 32'hC5);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x41 has two ones, parity bit 0
    expect_ok(8'h41);
    send_frame_par(8'h41, 1'b0);
    hold(1'b1, 20);
    expect_perr();
    send_frame_par(8'h41, 1'b1);
    hold(1'b1, 20);
    check("data_after_perr", {24'd0, data_o}, 32'h41);
`endif

    hold(1'b1, 30);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
